adder_pipelined: RTL

- Parametrised N-bit adder split into W-bit carry-chained segments, one segment per pipeline stage.
- Adds a valid/ready handshake with backpressure, so the ALU datapath can run wide adds at full clock rate with one result per cycle.
- Successor to the single-cycle combinational adder_n.
- Sits between operand registers and the writeback or accumulator logic.

---
 rtl/adder_pipelined.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/adder_pipelined.sv
// N-bit adder pipelined as W-bit carry-chained segments, one segment per stage,
// with a global-stall valid/ready handshake. Optional subtract mode: define ADDER_SUB_EN.
module adder_pipelined #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
`ifdef ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    localparam int unsigned STAGES = N / W;
    localparam int unsigned LAST   = STAGES - 1;

    if ((N % W) != 0) begin : g_bad_cfg
        $error("adder_pipelined: N must be an exact multiple of W");
    end

    logic advance;

    // Per-stage registers; operands shift down by W each stage so every stage adds bits [W-1:0]
    logic         valid_d [STAGES];
    logic         valid_q [STAGES];
    logic         carry_d [STAGES];
    logic         carry_q [STAGES];
    logic [N-1:0] sum_d   [STAGES];
    logic [N-1:0] sum_q   [STAGES];
    logic [N-1:0] a_op_d  [STAGES];
    logic [N-1:0] a_op_q  [STAGES];
    logic [N-1:0] b_op_d  [STAGES];
    logic [N-1:0] b_op_q  [STAGES];
    logic         sub_d   [STAGES];
    logic         sub_q   [STAGES];
    logic         ovf_d;
    logic         ovf_q;

    // Stage inputs: ports for stage 0, previous stage registers otherwise
    logic         src_valid [STAGES];
    logic         src_carry [STAGES];
    logic [N-1:0] src_sum   [STAGES];
    logic [N-1:0] src_a     [STAGES];
    logic [N-1:0] src_b     [STAGES];
    logic         src_sub   [STAGES];
    logic [W-1:0] b_seg     [STAGES];
    logic [W:0]   seg       [STAGES];

    assign advance = ~valid_q[LAST] | o_ready;
    assign i_ready = advance;

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            src_valid[k] = 1'b0;
            src_carry[k] = 1'b0;
            src_sum[k]   = '0;
            src_a[k]     = '0;
            src_b[k]     = '0;
            src_sub[k]   = 1'b0;
        end

        src_valid[0] = i_valid;
        src_sum[0]   = '0;
        src_a[0]     = a;
        src_b[0]     = b;
`ifdef ADDER_SUB_EN
        src_sub[0]   = sub;
        src_carry[0] = sub ? 1'b1 : c_in;
`else
        src_sub[0]   = 1'b0;
        src_carry[0] = c_in;
`endif

        for (int k = 1; k < int'(STAGES); k++) begin
            src_valid[k] = valid_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_sum[k]   = sum_q[k-1];
            src_a[k]     = a_op_q[k-1];
            src_b[k]     = b_op_q[k-1];
            src_sub[k]   = sub_q[k-1];
        end
    end

    // Segment adders and hold/advance selection
    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < int'(STAGES); k++) begin
            valid_d[k] = valid_q[k];
            carry_d[k] = carry_q[k];
            sum_d[k]   = sum_q[k];
            a_op_d[k]  = a_op_q[k];
            b_op_d[k]  = b_op_q[k];
            sub_d[k]   = sub_q[k];

            b_seg[k] = src_b[k][W-1:0] ^ {W{src_sub[k]}};
            seg[k]   = {1'b0, src_a[k][W-1:0]} + {1'b0, b_seg[k]} + (W+1)'(src_carry[k]);

            if (advance) begin
                valid_d[k] = src_valid[k];
                carry_d[k] = seg[k][W];
                sum_d[k]   = N'({seg[k][W-1:0], src_sum[k]} >> W);
                a_op_d[k]  = src_a[k] >> W;
                b_op_d[k]  = src_b[k] >> W;
                sub_d[k]   = src_sub[k];
            end
        end

        // Signed overflow: operand signs agree but result sign differs
        if (advance) begin
            ovf_d = (src_a[LAST][W-1] == b_seg[LAST][W-1]) &&
                    (seg[LAST][W-1] != src_a[LAST][W-1]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_op_q[k]  <= '0;
                b_op_q[k]  <= '0;
                sub_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
                a_op_q[k]  <= a_op_d[k];
                b_op_q[k]  <= b_op_d[k];
                sub_q[k]   <= sub_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign o_valid  = valid_q[LAST];
    assign sum      = sum_q[LAST];
    assign c_out    = carry_q[LAST];
    assign overflow = ovf_q;

endmodule
